// File: rtl/histo_mem_sched.sv
// Histogram SRAM sequencer: RMW bin accumulate (read at t, write at t+1), then blanking copy/cumulate/clear.
// No backpressure: frames arriving while busy are dropped with oDrop; `HISTO_FWD_EN` enables back-to-back write forwarding.
module histo_mem_sched #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 20
) (
  input  logic              iPclk,
  input  logic              iRst,
  input  logic              Fval,
  input  logic              Dval,
  input  logic [ADDR_W-1:0] Grey,
  input  logic [ADDR_W-1:0] iDisp_Addr,
  input  logic [CNT_W-1:0]  iAcc_Q,
  output logic [ADDR_W-1:0] oAcc_Raddr,
  output logic [ADDR_W-1:0] oAcc_Waddr,
  output logic [CNT_W-1:0]  oAcc_D,
  output logic              oAcc_Wen,
  output logic [ADDR_W-1:0] oDisp_Raddr,
  output logic [ADDR_W-1:0] oDisp_Waddr,
  output logic [CNT_W-1:0]  oDisp_D,
  output logic              oDisp_Wen,
  output logic [ADDR_W-1:0] oCum_Raddr,
  output logic [ADDR_W-1:0] oCum_Waddr,
  output logic [CNT_W-1:0]  oCum_D,
  output logic              oCum_Wen,
  output logic [2:0]        oState,
  output logic              oFrame_Done,
  output logic              oDrop
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FLUSH = 3'd2,
    COPY  = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  K_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              fval_d, s1_vld, cleared, cleared_nxt;
  logic [ADDR_W-1:0] s1_bin;
  logic [ADDR_W:0]   k, k_nxt, k_m1;
  logic [CNT_W-1:0]  sum, sum_nxt, acc_src, acc_inc, cum_sat;
  logic [CNT_W:0]    cum_wide;
  logic              rise, fall, pix;

  assign rise     = Fval & ~fval_d;
  assign fall     = ~Fval & fval_d;
  assign pix      = Fval & Dval & (state == ACCUM);
  assign k_m1     = k - K_ONE;
  assign cum_wide = {1'b0, sum} + {1'b0, iAcc_Q};
  assign cum_sat  = cum_wide[CNT_W] ? CNT_MAX : cum_wide[CNT_W-1:0];
  assign oState   = state;

  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      fval_d  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_bin  <= '0;
      k       <= '0;
      sum     <= '0;
      cleared <= 1'b0;
    end else begin
      state   <= state_nxt;
      fval_d  <= Fval;
      s1_vld  <= pix;
      if (pix) s1_bin <= Grey;
      k       <= k_nxt;
      sum     <= sum_nxt;
      cleared <= cleared_nxt;
    end
  end

`ifdef HISTO_FWD_EN
  // The SRAM returns old data when read and written in the same cycle, so reuse last cycle's write.
  logic              prev_wen;
  logic [ADDR_W-1:0] prev_waddr;
  logic [CNT_W-1:0]  prev_d;

  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) begin
      prev_wen   <= 1'b0;
      prev_waddr <= '0;
      prev_d     <= '0;
    end else begin
      prev_wen   <= oAcc_Wen;
      prev_waddr <= oAcc_Waddr;
      prev_d     <= oAcc_D;
    end
  end

  assign acc_src = (prev_wen && (prev_waddr == s1_bin)) ? prev_d : iAcc_Q;
`else
  assign acc_src = iAcc_Q;
`endif

  assign acc_inc = (acc_src == CNT_MAX) ? CNT_MAX : acc_src + CNT_ONE;

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    sum_nxt     = sum;
    cleared_nxt = cleared;
    oAcc_Raddr  = '0;
    oAcc_Waddr  = '0;
    oAcc_D      = '0;
    oAcc_Wen    = 1'b0;
    oDisp_Raddr = iDisp_Addr;
    oDisp_Waddr = '0;
    oDisp_D     = '0;
    oDisp_Wen   = 1'b0;
    oCum_Raddr  = iDisp_Addr;
    oCum_Waddr  = '0;
    oCum_D      = '0;
    oCum_Wen    = 1'b0;
    oFrame_Done = 1'b0;
    oDrop       = 1'b0;

    if (pix) oAcc_Raddr = Grey;
    if (s1_vld) begin
      oAcc_Waddr = s1_bin;
      oAcc_D     = acc_inc;
      oAcc_Wen   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (rise) begin
          // The accumulate bank holds garbage after reset: spend the first frame clearing it.
          if (cleared) begin
            state_nxt = ACCUM;
          end else begin
            state_nxt = CLEAR;
            k_nxt     = '0;
            oDrop     = 1'b1;
          end
        end
      end
      ACCUM: if (fall) state_nxt = FLUSH;
      FLUSH: begin
        state_nxt = COPY;
        k_nxt     = '0;
      end
      COPY: begin
        oDisp_Raddr = '0;
        oCum_Raddr  = '0;
        if (!k[ADDR_W]) oAcc_Raddr = k[ADDR_W-1:0];
        if (k != '0) begin
          oDisp_Waddr = k_m1[ADDR_W-1:0];
          oDisp_D     = iAcc_Q;
          oDisp_Wen   = 1'b1;
          oCum_Waddr  = k_m1[ADDR_W-1:0];
          oCum_D      = cum_sat;
          oCum_Wen    = 1'b1;
          sum_nxt     = cum_sat;
        end
        if (k[ADDR_W]) begin
          state_nxt = CLEAR;
          k_nxt     = '0;
          sum_nxt   = '0;
        end else begin
          k_nxt = k + K_ONE;
        end
      end
      CLEAR: begin
        oAcc_Waddr = k[ADDR_W-1:0];
        oAcc_D     = '0;
        oAcc_Wen   = 1'b1;
        if (k[ADDR_W-1:0] == '1) begin
          state_nxt   = DONE;
          cleared_nxt = 1'b1;
        end else begin
          k_nxt = k + K_ONE;
        end
      end
      DONE: begin
        oFrame_Done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A frame starting during DONE would also be missed by IDLE, so it is reported the same way.
    if (rise && (state == FLUSH || state == COPY || state == CLEAR || state == DONE))
      oDrop = 1'b1;

    if (iRst) begin
      oAcc_Raddr  = '0;
      oAcc_Waddr  = '0;
      oAcc_D      = '0;
      oAcc_Wen    = 1'b0;
      oDisp_Raddr = '0;
      oDisp_Waddr = '0;
      oDisp_D     = '0;
      oDisp_Wen   = 1'b0;
      oCum_Raddr  = '0;
      oCum_Waddr  = '0;
      oCum_D      = '0;
      oCum_Wen    = 1'b0;
      oFrame_Done = 1'b0;
      oDrop       = 1'b0;
    end
  end
endmodule

// File: tb/tb_histo_mem_sched.sv
// Directed bench for histo_mem_sched with behavioural models of the three histogram SRAMs.
module tb_histo_mem_sched;
  localparam int AW   = 8;
  localparam int CW   = 20;
  localparam int BINS = 256;
  localparam logic [CW-1:0] MAXV = '1;

  logic          clk = 1'b0;
  logic          rst, fval, dval;
  logic [AW-1:0] grey, disp_addr;
  logic [CW-1:0] acc_q = '0;
  logic [AW-1:0] acc_raddr, acc_waddr, disp_raddr, disp_waddr, cum_raddr, cum_waddr;
  logic [CW-1:0] acc_d, disp_d, cum_d;
  logic          acc_wen, disp_wen, cum_wen, done, drop;
  logic [2:0]    state_o;

  histo_mem_sched #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .iPclk(clk), .iRst(rst), .Fval(fval), .Dval(dval), .Grey(grey),
    .iDisp_Addr(disp_addr), .iAcc_Q(acc_q),
    .oAcc_Raddr(acc_raddr), .oAcc_Waddr(acc_waddr), .oAcc_D(acc_d), .oAcc_Wen(acc_wen),
    .oDisp_Raddr(disp_raddr), .oDisp_Waddr(disp_waddr), .oDisp_D(disp_d), .oDisp_Wen(disp_wen),
    .oCum_Raddr(cum_raddr), .oCum_Waddr(cum_waddr), .oCum_D(cum_d), .oCum_Wen(cum_wen),
    .oState(state_o), .oFrame_Done(done), .oDrop(drop)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] acc_mem [BINS];
  logic [CW-1:0] disp_mem[BINS];
  logic [CW-1:0] cum_mem [BINS];
  logic          pre_fill = 1'b0, pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [CW-1:0] pre_val = '0, w3_val = '0;
  int            disp_wr_cnt = 0;

  // Synchronous SRAMs: one-cycle read latency, read returns the pre-write contents.
  always @(posedge clk) begin
    acc_q <= acc_mem[acc_raddr];
    if (acc_wen) acc_mem[acc_waddr] <= acc_d;
    if (disp_wen) begin
      disp_mem[disp_waddr] <= disp_d;
      disp_wr_cnt <= disp_wr_cnt + 1;
    end
    if (cum_wen) cum_mem[cum_waddr] <= cum_d;
    if (acc_wen && acc_waddr == 8'd3 && state_o == 3'd1) w3_val <= acc_d;
    if (pre_fill) for (int i = 0; i < BINS; i++) acc_mem[i] <= CW'(i + 1);
    if (pre_en) acc_mem[pre_addr] <= pre_val;
  end

  int n_chk = 0;
  int n_err = 0;
  int pix_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_frame(input int gap);
    fval = 1'b1;
    @(negedge clk);
    check("accum_entry", 32'(state_o), 1);
    @(negedge clk);
    foreach (pix_q[i]) begin
      dval = 1'b1;
      grey = AW'(pix_q[i]);
      @(negedge clk);
      dval = 1'b0;
      repeat (gap) @(negedge clk);
    end
    fval = 1'b0;
    @(negedge clk);
    check("flush_entry", 32'(state_o), 2);
  endtask

  task automatic wait_done(output int dn, output int nc, output int ncl);
    logic ok;
    ok = 1'b0; dn = 0; nc = 0; ncl = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (state_o == 3'd3) nc++;
      if (state_o == 3'd4) ncl++;
      if (done) dn++;
      if (dn > 0 && state_o == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    check("seq_complete", 32'(ok), 1);
  endtask

  function automatic int acc_nonzero();
    int n = 0;
    for (int i = 0; i < BINS; i++) if (acc_mem[i] != '0) n++;
    return n;
  endfunction

  initial begin
    int dn, nc, ncl, bad_d, bad_c, rep_exp;
    rst = 1'b1; fval = 1'b0; dval = 1'b0; grey = '0; disp_addr = 8'h5A;
    #2;
    check("rst_state", 32'(state_o), 0);
    check("rst_acc_wen", 32'(acc_wen), 0);
    check("rst_disp_raddr", 32'(disp_raddr), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_disp_raddr", 32'(disp_raddr), 32'h5A);
    check("idle_cum_raddr", 32'(cum_raddr), 32'h5A);
    pre_fill = 1'b1;
    @(negedge clk); pre_fill = 1'b0;

    // First frame after reset only clears the accumulate bank
    fval = 1'b1; #1;
    check("first_drop", 32'(drop), 1);
    @(negedge clk);
    check("first_clear", 32'(state_o), 4);
    check("first_drop_pulse", 32'(drop), 0);
    wait_done(dn, nc, ncl);
    check("first_done", 32'(dn), 1);
    check("first_no_copy", 32'(nc), 0);
    check("first_clear_len", 32'(ncl), 255);
    fval = 1'b0;
    @(negedge clk);
    check("first_acc_zero", 32'(acc_nonzero()), 0);
    check("first_no_disp_wr", 32'(disp_wr_cnt), 0);

    // Distinct bins 0..255
    pix_q = {};
    for (int i = 0; i < BINS; i++) pix_q.push_back(i);
    run_frame(1);
    wait_done(dn, nc, ncl);
    check("dist_done", 32'(dn), 1);
    check("dist_copy_len", 32'(nc), 257);
    check("dist_clear_len", 32'(ncl), 256);
    bad_d = 0; bad_c = 0;
    for (int i = 0; i < BINS; i++) begin
      if (disp_mem[i] != CW'(1)) bad_d++;
      if (cum_mem[i] != CW'(i + 1)) bad_c++;
    end
    check("dist_disp_bad", 32'(bad_d), 0);
    check("dist_cum_bad", 32'(bad_c), 0);
    check("dist_cum255", 32'(cum_mem[255]), 256);
    check("dist_acc_zero", 32'(acc_nonzero()), 0);

    // Ten back-to-back pixels in bin 7
`ifdef HISTO_FWD_EN
    rep_exp = 10;
`else
    rep_exp = 5;
`endif
    pix_q = {};
    for (int i = 0; i < 10; i++) pix_q.push_back(7);
    run_frame(0);
    wait_done(dn, nc, ncl);
    check("rep_disp7", 32'(disp_mem[7]), 32'(rep_exp));
    check("rep_disp6", 32'(disp_mem[6]), 0);
    check("rep_cum6", 32'(cum_mem[6]), 0);
    check("rep_cum255", 32'(cum_mem[255]), 32'(rep_exp));

    // Frame arriving 100 cycles into COPY is dropped
    pix_q = {9};
    run_frame(2);
    repeat (101) @(negedge clk);
    check("busy_in_copy", 32'(state_o), 3);
    fval = 1'b1; #1;
    check("busy_drop", 32'(drop), 1);
    @(negedge clk);
    check("busy_drop_pulse", 32'(drop), 0);
    wait_done(dn, nc, ncl);
    check("busy_done_once", 32'(dn), 1);
    repeat (5) @(negedge clk);
    check("busy_stays_idle", 32'(state_o), 0);
    fval = 1'b0;
    @(negedge clk);
    check("busy_disp9", 32'(disp_mem[9]), 1);
    pix_q = {20, 20};
    run_frame(2);
    wait_done(dn, nc, ncl);
    check("after_busy_disp20", 32'(disp_mem[20]), 2);
    check("after_busy_disp9", 32'(disp_mem[9]), 0);
    check("after_busy_cum255", 32'(cum_mem[255]), 2);

    // Saturation of a preloaded bin and of the cumulative sum
    pre_addr = 8'd3; pre_val = MAXV; pre_en = 1'b1;
    @(negedge clk); pre_en = 1'b0;
    pix_q = {3, 5};
    run_frame(2);
    wait_done(dn, nc, ncl);
    check("sat_wdata", 32'(w3_val), 32'(MAXV));
    check("sat_disp3", 32'(disp_mem[3]), 32'(MAXV));
    check("sat_disp5", 32'(disp_mem[5]), 1);
    check("sat_cum2", 32'(cum_mem[2]), 0);
    check("sat_cum3", 32'(cum_mem[3]), 32'(MAXV));
    check("sat_cum5", 32'(cum_mem[5]), 32'(MAXV));
    check("sat_cum255", 32'(cum_mem[255]), 32'(MAXV));
    check("sat_acc3_cleared", 32'(acc_mem[3]), 0);

    // Asynchronous reset with a write in flight
    fval = 1'b1;
    @(negedge clk);
    check("mid_accum", 32'(state_o), 1);
    dval = 1'b1; grey = 8'd40;
    @(negedge clk);
    check("mid_wen_before", 32'(acc_wen), 1);
    rst = 1'b1; #1;
    check("mid_rst_state", 32'(state_o), 0);
    check("mid_rst_acc_wen", 32'(acc_wen), 0);
    check("mid_rst_disp_wen", 32'(disp_wen), 0);
    check("mid_rst_cum_wen", 32'(cum_wen), 0);
    check("mid_rst_waddr", 32'(acc_waddr), 0);
    check("mid_rst_raddr", 32'(acc_raddr), 0);
    dval = 1'b0; fval = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/histo_mem_sched.md
# histo_mem_sched

Sequencing controller for the three histogram SRAMs (accumulate, display and cumulative banks) in the camera video path. It owns all SRAM address, write-enable and write-data generation. During the active frame it performs read-modify-write bin accumulation with hazard forwarding. In frame blanking it copies the accumulate bank into the display bank, builds the cumulative bank, then clears the accumulate bank. It also grants display readout access to the display and cumulative banks.

## Interface
Parameters:
- `ADDR_W`, default 8: bin address width; BINS = 2^ADDR_W.
- `CNT_W`, default 20: bin count width; matches the SRAM data width.

Ports:
- `iPclk` in 1: pixel clock. All logic is on the rising edge.
- `iRst` in 1: reset, asynchronous, active-high.
- `Fval` in 1: frame valid.
- `Dval` in 1: pixel valid; only qualified while `Fval`=1.
- `Grey` in ADDR_W: bin index of the current pixel.
- `iDisp_Addr` in ADDR_W: display readout bin, taken from the display Y counter.
- `iAcc_Q` in CNT_W: accumulate bank read data; 1-cycle read latency.
- `oAcc_Raddr` out ADDR_W, `oAcc_Waddr` out ADDR_W, `oAcc_D` out CNT_W, `oAcc_Wen` out 1: accumulate bank control.
- `oDisp_Raddr` out ADDR_W, `oDisp_Waddr` out ADDR_W, `oDisp_D` out CNT_W, `oDisp_Wen` out 1: display bank control.
- `oCum_Raddr` out ADDR_W, `oCum_Waddr` out ADDR_W, `oCum_D` out CNT_W, `oCum_Wen` out 1: cumulative bank control.
- `oState` out 3: current state encoding.
- `oFrame_Done` out 1: one-cycle pulse when the DONE state is entered.
- `oDrop` out 1: one-cycle pulse when a frame is ignored because the block was busy.

## Operation
States and encodings: IDLE=0, ACCUM=1, FLUSH=2, COPY=3, CLEAR=4, DONE=5.

- **Reset.** State goes to IDLE. The counter `k`, the cumulative sum, all pipeline registers, all `*_Wen`, `oFrame_Done` and `oDrop` go to 0. All address and data outputs go to 0.
- **IDLE.**
  - A `Fval` rising edge (0→1, registered) moves the block to ACCUM.
  - Display and cumulative read addresses equal `iDisp_Addr`. This holds in every state except COPY.
- **ACCUM.**
  - Each cycle with `Fval&Dval`: `oAcc_Raddr`=`Grey`, and the bin is registered into stage 1.
  - Next cycle: `oAcc_Waddr`=stage-1 bin, `oAcc_Wen`=1, `oAcc_D`=src+1, saturating at 2^CNT_W-1.
  - src is `iAcc_Q`, or the forwarded value (see Configuration).
  - A `Fval` falling edge moves the block to FLUSH.
- **FLUSH.** One cycle that completes any pending write, then goes to COPY with `k`=0.
- **COPY** (BINS+1 cycles).
  - Cycle j, for j<BINS: `oAcc_Raddr`=j.
  - Cycle j, for j≥1: write index j-1 with `iAcc_Q` to the display bank (`oDisp_Waddr`=j-1, `oDisp_D`=`iAcc_Q`).
  - In the same cycle, add `iAcc_Q` to the running sum. Write the updated sum to the cumulative bank (`oCum_Waddr`=j-1, `oCum_D`=updated sum), saturating at 2^CNT_W-1.
  - After the write to index BINS-1, go to CLEAR with `k`=0 and the sum cleared.
- **CLEAR** (BINS cycles). `oAcc_Waddr`=`k`, `oAcc_D`=0, `oAcc_Wen`=1. After `k`=BINS-1, go to DONE.
- **DONE.** Pulse `oFrame_Done`, then go to IDLE.
- **Busy frames.** A `Fval` rising edge during FLUSH, COPY or CLEAR pulses `oDrop`. That frame is not accumulated; the sequence finishes normally and the block waits in IDLE for the next rising edge.
- **Missing first clear.** After reset the accumulate bank is not cleared. The first frame after reset runs a CLEAR-only pass: it pulses `oDrop` and accumulates nothing.

## Timing
- **Accumulate latency.** A pixel sampled at cycle t is read at t and written at t+1. A `Fval` fall at cycle t guarantees all writes are done by t+1 (the FLUSH cycle).
- **Same-cycle read/write.** A read and a write to the same address in the same cycle returns old data; the forwarding path covers this case.
- **Blanking requirement.** COPY+CLEAR+DONE takes 2·BINS+2 cycles after FLUSH, i.e. 514 cycles at ADDR_W=8. Vertical blanking must exceed 515 cycles.
- **Mid-operation reset.** Reset asserted during any state aborts immediately to IDLE with all write enables low. Bank contents are undefined until the next full sequence.

## Configuration
- **`HISTO_FWD_EN` defined.**
  - The block keeps the previous write address, data and enable.
  - If the current write address equals the previous cycle's write address and the previous write was enabled, src = previous `oAcc_D`; otherwise src = `iAcc_Q`.
  - Back-to-back identical bins therefore count exactly.
- **`HISTO_FWD_EN` not defined.** src = `iAcc_Q` always. A run of N consecutive identical bins undercounts by floor(N/2); this is accepted as a lower-area mode.

## Test plan
- **Reset.** Assert `iRst` mid-ACCUM → `oState`=0, all `*_Wen`=0 in the same cycle (asynchronous), outputs 0.
- **Distinct bins.** One frame of pixels 0,1,2,…,255, each once, separated by idle cycles → display bank = 1 at every bin, cumulative bank[i]=i+1, accumulate bank all 0 after DONE.
- **Repeated bin, forwarding on.** One frame of 10 consecutive cycles of `Grey`=7 with `HISTO_FWD_EN` defined → display[7]=10 and cumulative[255]=10.
- **Repeated bin, forwarding off.** Same stimulus without `HISTO_FWD_EN` → display[7]=5.
- **Busy frame.** `Fval` rises 100 cycles into COPY → `oDrop` pulses for one cycle, the copy completes, `oFrame_Done` pulses once, and the next frame accumulates normally.
- **Saturation.** Preload accumulate bin 3 = 2^20-1, then one pixel of bin 3 → write data stays 2^20-1, and the cumulative values from bin 3 onward are saturated at 2^20-1.
